// File: rtl/irq_req_sequencer_if.sv
// Request/ack bundle between the sequencer and the interrupt controller.
// master: sequencer side; slave: controller and event-source side.
interface irq_req_sequencer_if;
  logic [26:0] evt_i;
  logic [26:0] mask_i;
  logic [8:0]  req_a_o;
  logic [8:0]  req_b_o;
  logic [8:0]  req_c_o;
  logic        req_valid_o;
  logic        ack_i;
  logic [1:0]  ack_bus_i;
  logic [3:0]  ack_chan_i;
  logic [26:0] ovf_o;
  logic        ovf_clr_i;
  logic        timeout_o;
  logic        busy_o;

  modport master (
    input  evt_i, mask_i, ack_i, ack_bus_i,
    input  ack_chan_i, ovf_clr_i,
    output req_a_o, req_b_o, req_c_o,
    output req_valid_o, ovf_o, timeout_o, busy_o
  );

  modport slave (
    output evt_i, mask_i, ack_i, ack_bus_i,
    output ack_chan_i, ovf_clr_i,
    input  req_a_o, req_b_o, req_c_o,
    input  req_valid_o, ovf_o, timeout_o, busy_o
  );
endinterface

// File: rtl/irq_req_sequencer.sv
// Latches 27 event channels into pending bits, presents a stable snapshot
// to the priority controller and retires the acknowledged channel.
//   clk, rst : clock, async active-high reset
//   sq       : irq_req_sequencer_if.master (events, mask, snapshot,
//              ack, overflow, timeout, busy)
module irq_req_sequencer #(
  parameter int TIMEOUT = 64,
  parameter int HOLDOFF = 2,
  parameter int CNT_W   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  irq_req_sequencer_if.master        sq
);
  typedef enum logic [1:0] {
    IDLE, REQ, CLR, HOLD
  } state_t;

  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] HO_LAST =
    CNT_W'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

  state_t           state_q, state_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic [26:0]      pend_q, pend_n;
  logic [26:0]      snap_q, snap_n;
  logic [26:0]      ovf_q, ovf_n;
  logic [4:0]       idx_q, idx_n;
  logic             tmo_q, tmo_n;
  logic             valid_q, busy_q;

  logic [26:0] hit;
  logic [26:0] clr_bit;
  logic [5:0]  ack_idx;
  logic [31:0] snap_ext;
  logic        ack_ok;

  assign hit      = sq.evt_i & sq.mask_i;
  assign ack_idx  = 6'(sq.ack_bus_i) * 6'd9
                  + 6'(sq.ack_chan_i);
  assign snap_ext = {5'd0, snap_q};
  assign ack_ok   = sq.ack_i
                  && (sq.ack_bus_i < 2'd3)
                  && (sq.ack_chan_i < 4'd9)
                  && snap_ext[ack_idx[4:0]];

  // Retired bit only exists in CLR; a same-cycle event re-sets it
  // and is not an overflow.
  assign clr_bit = (state_q == CLR)
                 ? (27'(1) << idx_q) : '0;
  assign pend_n  = (pend_q & ~clr_bit) | hit;
  assign ovf_n   = (ovf_q & ~{27{sq.ovf_clr_i}})
                 | (hit & pend_q & ~clr_bit);

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    snap_n  = snap_q;
    idx_n   = idx_q;
    tmo_n   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|(pend_q & sq.mask_i)) begin
          snap_n  = pend_q & sq.mask_i;
          cnt_n   = '0;
          state_n = REQ;
        end
      end
      REQ: begin
        cnt_n = cnt_q + CNT_W'(1);
        if (ack_ok) begin
          idx_n   = ack_idx[4:0];
          state_n = CLR;
        end else if (cnt_q == TO_LAST) begin
          tmo_n   = 1'b1;
          state_n = IDLE;
        end
      end
      CLR: begin
        cnt_n   = '0;
        state_n = (HOLDOFF == 0) ? IDLE : HOLD;
      end
      HOLD: begin
        cnt_n = cnt_q + CNT_W'(1);
        if (cnt_q == HO_LAST) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      snap_q  <= '0;
      ovf_q   <= '0;
      idx_q   <= '0;
      tmo_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      pend_q  <= pend_n;
      snap_q  <= snap_n;
      ovf_q   <= ovf_n;
      idx_q   <= idx_n;
      tmo_q   <= tmo_n;
      valid_q <= (state_n == REQ);
      busy_q  <= (state_n != IDLE);
    end
  end

  // Timeout pulse shows up in the first cycle back in IDLE.
  assign sq.req_a_o     = snap_q[8:0];
  assign sq.req_b_o     = snap_q[17:9];
  assign sq.req_c_o     = snap_q[26:18];
  assign sq.req_valid_o = valid_q;
  assign sq.ovf_o       = ovf_q;
  assign sq.timeout_o   = tmo_q;
  assign sq.busy_o      = busy_q;
endmodule

// File: tb/tb_irq_req_sequencer.sv
// Scoreboard bench for irq_req_sequencer: directed scenarios plus
// random traffic, checked against a behavioural model.
module tb_irq_req_sequencer;
  localparam int TIMEOUT = 64;
  localparam int HOLDOFF = 2;
  localparam logic [26:0] ALL = '1;

  logic clk;
  logic rst;
  irq_req_sequencer_if bif();

  irq_req_sequencer #(
    .TIMEOUT(TIMEOUT),
    .HOLDOFF(HOLDOFF),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sq(bif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;
  int tmo_seen = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum {M_IDLE, M_REQ, M_CLR, M_HOLD} mph_t;
  mph_t        ph = M_IDLE;
  logic [26:0] m_pend = '0;
  logic [26:0] m_ovf = '0;
  logic [26:0] m_snap = '0;
  int          age = 0;
  int          hold_left = 0;
  int          clr_idx = 0;
  bit          m_tmo = 0;

  typedef struct {
    bit          valid;
    bit          busy;
    bit          tmo;
    logic [26:0] req;
    logic [26:0] ovf;
  } exp_t;
  exp_t sb[$];

  task automatic model_step(input logic [26:0] evt,
                            input logic [26:0] msk,
                            input bit ack, input int abus,
                            input int achan, input bit oclr,
                            input bit r);
    logic [26:0] hit;
    bit   clearing, self;
    mph_t nx;
    m_tmo = 0;
    if (r) begin
      ph = M_IDLE; m_pend = '0; m_ovf = '0;
      m_snap = '0; age = 0; hold_left = 0;
      return;
    end
    hit = evt & msk;
    clearing = (ph == M_CLR);
    nx = ph;
    case (ph)
      M_IDLE:
        if ((m_pend & msk) != 0) begin
          m_snap = m_pend & msk;
          age = 0;
          nx = M_REQ;
        end
      M_REQ: begin
        age++;
        if (ack && abus < 3 && achan < 9
            && m_snap[abus*9+achan]) begin
          clr_idx = abus * 9 + achan;
          nx = M_CLR;
        end else if (age == TIMEOUT) begin
          m_tmo = 1;
          nx = M_IDLE;
        end
      end
      M_CLR: begin
        hold_left = HOLDOFF;
        nx = (HOLDOFF == 0) ? M_IDLE : M_HOLD;
      end
      default: begin
        hold_left--;
        if (hold_left == 0) nx = M_IDLE;
      end
    endcase
    if (oclr) m_ovf = '0;
    for (int i = 0; i < 27; i++) begin
      self = clearing && (i == clr_idx);
      if (hit[i]) begin
        if (m_pend[i] && !self) m_ovf[i] = 1'b1;
        m_pend[i] = 1'b1;
      end else if (self) begin
        m_pend[i] = 1'b0;
      end
    end
    ph = nx;
  endtask

  // One clock: drive at negedge, predict, return after the edge.
  task automatic cyc(input logic [26:0] evt,
                     input logic [26:0] msk,
                     input bit ack = 0, input int abus = 0,
                     input int achan = 0, input bit oclr = 0,
                     input bit r = 0);
    exp_t e;
    @(negedge clk);
    rst = r;
    bif.evt_i = evt;
    bif.mask_i = msk;
    bif.ack_i = ack;
    bif.ack_bus_i = abus[1:0];
    bif.ack_chan_i = achan[3:0];
    bif.ovf_clr_i = oclr;
    model_step(evt, msk, ack, abus, achan, oclr, r);
    e.valid = (ph == M_REQ);
    e.busy  = (ph != M_IDLE);
    e.tmo   = m_tmo;
    e.req   = m_snap;
    e.ovf   = m_ovf;
    sb.push_back(e);
    if (r) begin
      #1;
      chk("rst_outputs_zero",
          {7'd0, bif.req_valid_o, bif.busy_o,
           bif.timeout_o, bif.ovf_o, bif.req_c_o,
           bif.req_b_o, bif.req_a_o}, 64'd0);
    end
    @(posedge clk);
    #2;
  endtask

  task automatic wait_req(input logic [26:0] msk);
    int n = 0;
    while (ph != M_REQ && n < 40) begin
      cyc('0, msk);
      n++;
    end
    if (ph != M_REQ) begin
      errors++;
      $display("FAIL wait_req: no REQ after %0d", n);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc('0, ALL);
  endtask

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    @(negedge clk);
    forever begin
      @(posedge clk);
      #1;
      if (bif.timeout_o === 1'b1) tmo_seen++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_empty: no expected entry");
      end else begin
        e = sb.pop_front();
        chk("ctl_valid_busy_tmo",
            {61'd0, bif.req_valid_o, bif.busy_o,
             bif.timeout_o},
            {61'd0, e.valid, e.busy, e.tmo});
        chk("ovf", {37'd0, bif.ovf_o}, {37'd0, e.ovf});
        if (e.valid)
          chk("req_snapshot",
              {37'd0, bif.req_c_o, bif.req_b_o,
               bif.req_a_o}, {37'd0, e.req});
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int t0;
    logic [26:0] ev, mk;
    int s, idx;
    rst = 1'b1;
    bif.evt_i = '0;
    bif.mask_i = '0;
    bif.ack_i = 1'b0;
    bif.ack_bus_i = '0;
    bif.ack_chan_i = '0;
    bif.ovf_clr_i = 1'b0;

    for (int i = 0; i < 3; i++) cyc('0, ALL, 0, 0, 0, 0, 1);
    idle(2);

    // 1: single event, latency, ack, holdoff
    cyc(27'h1, ALL);
    chk("t1_valid_t1", {63'd0, bif.req_valid_o}, 64'd0);
    cyc('0, ALL);
    chk("t1_valid_t2", {63'd0, bif.req_valid_o}, 64'd1);
    chk("t1_req_a", {55'd0, bif.req_a_o}, 64'h001);
    cyc('0, ALL, 1, 0, 0);
    cyc('0, ALL);
    chk("t1_clr_valid", {63'd0, bif.req_valid_o}, 64'd0);
    idle(2);
    chk("t1_idle_busy", {63'd0, bif.busy_o}, 64'd0);
    idle(2);

    // 2: three buses, ack B4
    cyc((27'h1 << 3) | (27'h1 << 13) | (27'h1 << 26), ALL);
    wait_req(ALL);
    chk("t2_snap",
        {37'd0, bif.req_c_o, bif.req_b_o, bif.req_a_o},
        {37'd0, 9'h100, 9'h010, 9'h008});
    cyc('0, ALL, 1, 1, 4);
    wait_req(ALL);
    chk("t2_resnap",
        {37'd0, bif.req_c_o, bif.req_b_o, bif.req_a_o},
        {37'd0, 9'h100, 9'h000, 9'h008});
    cyc('0, ALL, 1, 0, 3);
    wait_req(ALL);
    cyc('0, ALL, 1, 2, 8);
    idle(5);

    // 3: timeout, then 4: invalid acks and ack on last cycle
    cyc(27'h1 << 7, ALL);
    wait_req(ALL);
    t0 = tmo_seen;
    for (int i = 0; i < TIMEOUT; i++) cyc('0, ALL);
    wait_req(ALL);
    chk("t3_tmo_once", 64'(tmo_seen - t0), 64'd1);
    chk("t3_resnap", {55'd0, bif.req_a_o}, 64'h080);
    cyc('0, ALL, 1, 3, 0);
    cyc('0, ALL, 1, 0, 9);
    cyc('0, ALL, 1, 0, 0);
    chk("t4_still_req", {63'd0, bif.req_valid_o}, 64'd1);
    for (int i = 0; i < TIMEOUT - 4; i++) cyc('0, ALL);
    cyc('0, ALL, 1, 0, 7);
    idle(4);
    chk("t4_no_tmo", 64'(tmo_seen - t0), 64'd1);

    // 5: overflow set, clear race, event during CLR
    cyc(27'h1 << 5, ALL);
    cyc(27'h1 << 5, ALL);
    chk("t5_ovf_set", {63'd0, bif.ovf_o[5]}, 64'd1);
    cyc(27'h1 << 5, ALL, 0, 0, 0, 1);
    chk("t5_ovf_wins", {63'd0, bif.ovf_o[5]}, 64'd1);
    cyc('0, ALL, 0, 0, 0, 1);
    chk("t5_ovf_clr", {63'd0, bif.ovf_o[5]}, 64'd0);
    wait_req(ALL);
    cyc('0, ALL, 1, 0, 5);
    cyc(27'h1 << 5, ALL);
    chk("t5_clr_no_ovf", {63'd0, bif.ovf_o[5]}, 64'd0);
    wait_req(ALL);
    chk("t5_repend", {55'd0, bif.req_a_o}, 64'h020);
    cyc('0, ALL, 1, 0, 5);
    idle(4);

    // mask drop after snapshot keeps the request stable
    cyc(27'h2, ALL);
    wait_req(ALL);
    cyc(27'h2, ALL & ~27'h2);
    cyc('0, ALL & ~27'h2);
    chk("mask_hold", {55'd0, bif.req_a_o}, 64'h002);
    cyc('0, ALL & ~27'h2, 1, 0, 1);
    idle(4);

    // 6: reset during REQ
    cyc(27'h4, ALL);
    wait_req(ALL);
    cyc('0, ALL, 0, 0, 0, 0, 1);
    cyc('0, ALL, 0, 0, 0, 0, 1);
    idle(4);
    chk("t6_idle", {62'd0, bif.req_valid_o, bif.busy_o},
        64'd0);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      ev = '0;
      if ($urandom_range(0, 3) == 0)
        ev = 27'h1 << $urandom_range(0, 26);
      else if ($urandom_range(0, 15) == 0)
        ev = 27'($urandom);
      mk = ($urandom_range(0, 7) == 0)
         ? 27'($urandom) : ALL;
      if (ph == M_REQ && $urandom_range(0, 2) == 0) begin
        if ($urandom_range(0, 9) < 7) begin
          s = $urandom_range(0, 26);
          idx = 0;
          for (int k = 0; k < 27; k++)
            if (m_snap[(s + k) % 27]) begin
              idx = (s + k) % 27;
              break;
            end
          cyc(ev, mk, 1, idx / 9, idx % 9,
              $urandom_range(0, 15) == 0);
        end else begin
          cyc(ev, mk, 1, $urandom_range(0, 3),
              $urandom_range(0, 15),
              $urandom_range(0, 15) == 0);
        end
      end else begin
        cyc(ev, mk, 0, 0, 0, $urandom_range(0, 15) == 0,
            $urandom_range(0, 599) == 0);
      end
    end
    idle(8);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
